line_reader: RTL and testbench

LINE_READER -- requirements
Module: line_reader

---
 rtl/line_reader_pkg.sv | 14 +
 rtl/line_reader_skid_fifo2.sv | 71 +++++++
 rtl/line_reader.sv | 141 ++++++++++++++
 tb/tb_line_reader.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/line_reader_pkg.sv
// Shared definitions for the line reader: default geometry and FSM state encoding.
package line_reader_pkg;

  localparam int LR_DEPTH  = 76;
  localparam int LR_DATA_W = 32;
  localparam int LR_ADDR_W = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/line_reader_skid_fifo2.sv
// Two-entry FIFO between the memory read pipeline and the output port.
// A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
module skid_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] entry_q [2];
  logic [W-1:0] entry_d [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s, do_pop_s;

  assign empty     = (count_q == 2'd0);
  assign full      = (count_q == 2'd2);
  assign count     = count_q;
  assign head_data = entry_q[rd_ptr_q];

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    entry_d   = entry_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    do_pop_s  = pop & ~empty;
    do_push_s = push & (~full | do_pop_s);
    if (do_push_s) begin
      entry_d[wr_ptr_q] = push_data;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_q[0] <= {W{1'b0}};
      entry_q[1] <= {W{1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q    <= entry_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: rtl/line_reader.sv
// Streams one line of words out of a synchronous-read memory onto a valid/ready port.
// Reads are throttled so FIFO entries plus the read in flight never exceed two.
module line_reader
  import line_reader_pkg::*;
#(
  parameter int DEPTH  = LR_DEPTH,
  parameter int DATA_W = LR_DATA_W,
  parameter int ADDR_W = LR_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] line_len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write_en,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] last_addr_q, last_addr_d;
  logic              pending_q, pending_d;
  logic              pending_last_q, pending_last_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [ADDR_W-1:0] eff_len_s;
  logic [2:0]        occ_s;
  logic              pop_s, issue_s, final_issue_s;
  logic [DATA_W:0]   head_s;
  logic [1:0]        fifo_count_s;
  logic              full_s, empty_s;

  skid_fifo2 #(.W(DATA_W + 1)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (pending_q),
    .push_data ({pending_last_q, mem_rd_data}),
    .pop       (pop_s),
    .head_data (head_s),
    .count     (fifo_count_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign out_valid    = ~empty_s;
  assign out_data     = head_s[DATA_W-1:0];
  assign out_last     = head_s[DATA_W] & ~empty_s;
  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_addr     = addr_q;
  assign mem_write_en = 1'b0;

  // Issue throttle: occupancy after this cycle's pop must leave room for one more read.
  always_comb begin
    pop_s         = ~empty_s & out_ready;
    occ_s         = {1'b0, fifo_count_s} + {2'b00, pending_q} - {2'b00, pop_s};
    issue_s       = (state_q == ST_READ) && (occ_s < 3'd2) && !(full_s && !pop_s);
    final_issue_s = issue_s && (addr_q == last_addr_q);
    if ((line_len == {ADDR_W{1'b0}}) || (line_len > DEPTH_A)) begin
      eff_len_s = DEPTH_A;
    end else begin
      eff_len_s = line_len;
    end
  end

  // FSM next state, address walk and done/busy generation.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    last_addr_d    = last_addr_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    pending_d      = issue_s;
    pending_last_d = final_issue_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_READ;
          busy_d      = 1'b1;
          addr_d      = {ADDR_W{1'b0}};
          last_addr_d = eff_len_s - ADDR_W'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (final_issue_s) begin
          state_d = ST_DRAIN;
        end else if (issue_s) begin
          addr_d = addr_q + ADDR_W'(1);
        end else begin
          addr_d = addr_q;
        end
      end
      ST_DRAIN: begin
        if (pop_s && head_s[DATA_W]) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      addr_q         <= {ADDR_W{1'b0}};
      last_addr_q    <= {ADDR_W{1'b0}};
      pending_q      <= 1'b0;
      pending_last_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      last_addr_q    <= last_addr_d;
      pending_q      <= pending_d;
      pending_last_q <= pending_last_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
    end
  end

endmodule

// File: tb/tb_line_reader.sv
// Directed, table-driven bench for line_reader with a synchronous-read memory model.
module tb_line_reader;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [6:0]  line_len;
  logic        busy;
  logic        done;
  logic [6:0]  mem_addr;
  logic        mem_write_en;
  logic [31:0] mem_rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  logic [31:0] mem [128];
  int          errors;
  int          checks;

  typedef struct {
    logic [6:0] len;
    int         mode;
    int         exp_n;
    int         restart_at;
  } vec_t;

  vec_t vecs [7];

  line_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .line_len     (line_len),
    .busy         (busy),
    .done         (done),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_rd_data  (mem_rd_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) mem_rd_data <= mem[mem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic ready_pat(input int mode, input int cyc);
    if (mode == 1) return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    return 1'b1;
  endfunction

  task automatic run_line(input vec_t v);
    int          got;
    int          cyc;
    int          dones;
    bit          fin;
    bit          stalled;
    logic [31:0] hold_d;
    logic        hold_l;
    got = 0; cyc = 0; dones = 0; fin = 0; stalled = 0;
    hold_d = 32'h0; hold_l = 1'b0;
    @(negedge clk);
    start = 1'b1;
    line_len = v.len;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 400) begin
      start = 1'b0;
      out_ready = ready_pat(v.mode, cyc);
      if (v.mode == 0 && cyc < 2) chk("early_valid", {31'd0, out_valid}, 32'd0);
      if (v.mode == 0 && cyc == 2) chk("first_valid_latency", {31'd0, out_valid}, 32'd1);
      if (v.mode == 0 && got > 0 && got < v.exp_n) chk("consecutive_valid", {31'd0, out_valid}, 32'd1);
      if (busy) chk("addr_bound", {31'd0, mem_addr < 7'(v.exp_n)}, 32'd1);
      if (stalled) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_data", out_data, hold_d);
        chk("stall_last", {31'd0, out_last}, {31'd0, hold_l});
      end
      if (out_valid && out_ready) begin
        chk("word_data", out_data, 32'h100 + 32'(got));
        chk("word_last", {31'd0, out_last}, {31'd0, got == v.exp_n - 1});
        if (got == v.restart_at) begin
          start = 1'b1;
          line_len = 7'd3;
        end
        got++;
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1;
        hold_d = out_data;
        hold_l = out_last;
      end else begin
        stalled = 0;
      end
      if (done) begin
        dones++;
        fin = 1;
        chk("busy_low_with_done", {31'd0, busy}, 32'd0);
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("done_count", 32'(dones), 32'd1);
    chk("word_count", 32'(got), 32'(v.exp_n));
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("idle_no_valid", {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int got;
    int cyc;
    errors = 0;
    checks = 0;
    for (int i = 0; i < 128; i++) mem[i] = 32'h100 + 32'(i);
    vecs[0] = '{len: 7'd76,  mode: 0, exp_n: 76, restart_at: -1};
    vecs[1] = '{len: 7'd0,   mode: 0, exp_n: 76, restart_at: -1};
    vecs[2] = '{len: 7'd5,   mode: 1, exp_n: 5,  restart_at: -1};
    vecs[3] = '{len: 7'd1,   mode: 0, exp_n: 1,  restart_at: -1};
    vecs[4] = '{len: 7'd76,  mode: 0, exp_n: 76, restart_at: 10};
    vecs[5] = '{len: 7'd100, mode: 0, exp_n: 76, restart_at: -1};
    vecs[6] = '{len: 7'd2,   mode: 1, exp_n: 2,  restart_at: -1};

    rst_n = 1'b0; start = 1'b0; line_len = 7'd0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_last", {31'd0, out_last}, 32'd0);
    chk("rst_addr", {25'd0, mem_addr}, 32'd0);
    chk("rst_wen", {31'd0, mem_write_en}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_line(vecs[i]);

    // Abort a 76-word line after 30 words with reset, then run a short line.
    @(negedge clk);
    start = 1'b1; line_len = 7'd76; out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    got = 0; cyc = 0;
    while (got < 30 && cyc < 200) begin
      if (out_valid && out_ready) got++;
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached_word30", 32'(got), 32'd30);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_addr", {25'd0, mem_addr}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("abort_no_done", {31'd0, done}, 32'd0);
      chk("abort_no_valid", {31'd0, out_valid}, 32'd0);
    end
    run_line('{len: 7'd3, mode: 0, exp_n: 3, restart_at: -1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
